axi4_slave_mem: RTL and testbench

- AXI4-Full slave (responder) backed by on-chip word memory; the target end of the AXI4 master command block (write/read, 24-bit address, 8-bit burst length, 32-bit data).
- Serves INCR and FIXED bursts of up to 256 beats on independent write and read channels, with one outstanding transaction per direction.
- Used as the memory endpoint in block designs and benches that exercise the master.

---
 rtl/axi4_pkg.sv | 22 ++
 rtl/axi4_slave_ram.sv | 33 +++
 rtl/axi4_slave_mem.sv | 226 ++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, channel FSM states and burst qualification
// for the word-memory responder.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Only full-word FIXED/INCR bursts are serviced; anything else is answered with SLVERR.
    function automatic logic burst_unsupported(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == BURST_FIXED || burst == BURST_INCR) || (size != SIZE_4B);
    endfunction

endpackage

// File: rtl/axi4_slave_ram.sv
// DEPTH x 32 memory: byte-enabled write port and a registered read port
// that returns the pre-write contents on a same-cycle collision.
module axi4_slave_ram #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4-Full responder over on-chip word memory: independent write and read
// channel FSMs, one outstanding burst each, INCR/FIXED up to 256 beats.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-2:0] DEPTH_W = (ADDR_W-1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a[ADDR_W-1:2]} < DEPTH_W;
    endfunction

    // ---------------- write channel ----------------
    wr_state_t         wr_state_q, wr_state_d;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wbeat_q, wbeat_d;
    logic              wincr_q, wbad_q, werr_q, werr_d;
    logic              aw_fire, w_fire, w_last_beat, w_in_range, ram_we;

    assign aw_fire     = s_axi_awvalid && awready_q;
    assign w_fire      = s_axi_wvalid && wready_q;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign w_in_range  = in_range(waddr_q);
    assign ram_we      = w_fire && !wbad_q && w_in_range;

    always_comb begin
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        case (wr_state_q)
            W_IDLE: if (aw_fire) begin
                wr_state_d = W_DATA;
                waddr_d    = s_axi_awaddr;
                wbeat_d    = '0;
                werr_d     = burst_unsupported(s_axi_awburst, s_axi_awsize);
            end
            W_DATA: if (w_fire) begin
                // beat count terminates the burst; a misplaced wlast only flags the response
                if (!w_in_range || (s_axi_wlast != w_last_beat)) werr_d = 1'b1;
                if (wincr_q) waddr_d = waddr_q + ADDR_W'(4);
                wbeat_d = wbeat_q + 8'd1;
                if (w_last_beat) wr_state_d = W_RESP;
            end
            W_RESP: if (bvalid_q && s_axi_bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            bid_q      <= '0;
            waddr_q    <= '0;
            wbeat_q    <= '0;
            wlen_q     <= '0;
            wincr_q    <= 1'b0;
            wbad_q     <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= (wr_state_d == W_IDLE);
            wready_q   <= (wr_state_d == W_DATA);
            bvalid_q   <= (wr_state_d == W_RESP);
            bresp_q    <= (wr_state_d == W_RESP && werr_d) ? RESP_SLVERR : RESP_OKAY;
            waddr_q    <= waddr_d;
            wbeat_q    <= wbeat_d;
            werr_q     <= werr_d;
            if (aw_fire) begin
                bid_q   <= s_axi_awid;
                wlen_q  <= s_axi_awlen;
                wincr_q <= (s_axi_awburst == BURST_INCR);
                wbad_q  <= burst_unsupported(s_axi_awburst, s_axi_awsize);
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_t         rd_state_q, rd_state_d;
    logic              arready_q, rvalid_q, rlast_q, rzero_q;
    logic [1:0]        rresp_q;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] raddr_q, r_addr_d;
    logic [7:0]        rlen_q, rbeat_q, r_len_d, r_beat_d;
    logic              rincr_q, rbad_q, r_bad_d, r_issue, r_in_range;
    logic              ar_fire, r_fire;
    logic [31:0]       ram_rdata;

    assign ar_fire    = s_axi_arvalid && arready_q;
    assign r_fire     = rvalid_q && s_axi_rready;
    assign r_in_range = in_range(r_addr_d);

    // r_issue launches the RAM read for the beat that becomes visible next cycle
    always_comb begin
        rd_state_d = rd_state_q;
        r_issue    = 1'b0;
        r_addr_d   = rincr_q ? raddr_q + ADDR_W'(4) : raddr_q;
        r_beat_d   = rbeat_q + 8'd1;
        r_len_d    = rlen_q;
        r_bad_d    = rbad_q;
        case (rd_state_q)
            R_IDLE: if (ar_fire) begin
                rd_state_d = R_DATA;
                r_issue    = 1'b1;
                r_addr_d   = s_axi_araddr;
                r_beat_d   = '0;
                r_len_d    = s_axi_arlen;
                r_bad_d    = burst_unsupported(s_axi_arburst, s_axi_arsize);
            end
            R_DATA: if (r_fire) begin
                if (rlast_q) rd_state_d = R_IDLE;
                else         r_issue    = 1'b1;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rzero_q    <= 1'b1;
            rresp_q    <= '0;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rincr_q    <= 1'b0;
            rbad_q     <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= (rd_state_d == R_IDLE);
            rvalid_q   <= (rd_state_d == R_DATA);
            if (ar_fire) begin
                rid_q   <= s_axi_arid;
                rincr_q <= (s_axi_arburst == BURST_INCR);
            end
            if (r_issue) begin
                raddr_q <= r_addr_d;
                rbeat_q <= r_beat_d;
                rlen_q  <= r_len_d;
                rbad_q  <= r_bad_d;
                rlast_q <= (r_beat_d == r_len_d);
                rzero_q <= r_bad_d || !r_in_range;
                rresp_q <= (r_bad_d || !r_in_range) ? RESP_SLVERR : RESP_OKAY;
            end else if (r_fire && rlast_q) begin
                rlast_q <= 1'b0;
            end
        end
    end

    axi4_slave_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .we    (ram_we),
        .waddr (waddr_q[2 +: IDX_W]),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .re    (r_issue && r_in_range),
        .raddr (r_addr_d[2 +: IDX_W]),
        .rdata (ram_rdata)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rzero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: stimulus pushes expected B/R responses,
// a negedge monitor compares them against every presented response.
module tb_axi4_slave_mem;
    import axi4_pkg::*;

    localparam int ADDR_W = 24;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 1024;
    localparam int TMO    = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ID_W-1:0]   s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [ADDR_W-1:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]        s_axi_awlen, s_axi_arlen;
    logic [2:0]        s_axi_awsize, s_axi_arsize;
    logic [1:0]        s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic              s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [31:0]       s_axi_wdata, s_axi_rdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic              s_axi_rlast, s_axi_rvalid;
    logic              s_axi_rready = 1'b1;

    always #5 clk = ~clk;

    axi4_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(32), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct { logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    int     tests = 0;
    int     fails = 0;
    logic   bp_mode = 1'b0;
    int     pi = 0;
    logic [3:0] pat = 4'b1001;   // rready sequence 1,0,0,1

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got no handshake, expected one within %0d cycles", name, TMO);
    endfunction

    function automatic void exp_r(input logic [ID_W-1:0] id, input logic [31:0] d,
                                  input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endfunction

    function automatic void exp_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        bq.push_back(e);
    endfunction

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            s_axi_rready = pat[pi];
            pi = (pi + 1) % 4;
        end else begin
            s_axi_rready = 1'b1;
        end
    end

    // monitor: compare any presented response with the queue head, pop on handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (s_axi_rvalid) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_unexpected: got beat 0x%08h, expected none", s_axi_rdata);
                end else begin
                    check("rid",   32'(s_axi_rid),   32'(rq[0].id));
                    check("rdata", s_axi_rdata,      rq[0].data);
                    check("rresp", 32'(s_axi_rresp), 32'(rq[0].resp));
                    check("rlast", 32'(s_axi_rlast), 32'(rq[0].last));
                    if (s_axi_rready) void'(rq.pop_front());
                end
            end
            if (s_axi_bvalid) begin
                if (bq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected: got bresp %0d, expected none", s_axi_bresp);
                end else begin
                    check("bid",   32'(s_axi_bid),   32'(bq[0].id));
                    check("bresp", 32'(s_axi_bresp), 32'(bq[0].resp));
                    if (s_axi_bready) void'(bq.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [ID_W-1:0] id, input logic [23:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                            input int wlast_at);
        int n;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = SIZE_4B; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("aw_handshake");
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata = base + 32'(i); s_axi_wstrb = strb;
            s_axi_wlast = (i == wlast_at); s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) timeout("w_handshake");
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [23:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = SIZE_4B; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("ar_handshake");
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        check("r_latency", 32'(s_axi_rvalid), 32'd1);
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while ((rq.size() > 0 || bq.size() > 0) && cycles < TMO) begin @(posedge clk); #1; cycles++; end
        if (cycles >= TMO) begin
            timeout("drain");
            rq.delete();
            bq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected one before 500000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        rst_n = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(s_axi_awready), 0);
        check("rst_wready",  32'(s_axi_wready),  0);
        check("rst_bvalid",  32'(s_axi_bvalid),  0);
        check("rst_arready", 32'(s_axi_arready), 0);
        check("rst_rvalid",  32'(s_axi_rvalid),  0);
        check("rst_rdata",   s_axi_rdata,        0);
        check("rst_rlast",   32'(s_axi_rlast),   0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("awready_up", 32'(s_axi_awready), 1);
        check("arready_up", 32'(s_axi_arready), 1);

        // single write / read
        exp_b(4'd1, RESP_OKAY);
        do_write(4'd1, 24'h000004, 8'd0, BURST_INCR, 32'h55555555, 4'hF, 0);
        wait_drain(cyc);
        exp_r(4'd2, 32'h55555555, RESP_OKAY, 1'b1);
        do_read(4'd2, 24'h000004, 8'd0, BURST_INCR);
        wait_drain(cyc);

        // 16-beat INCR, back-to-back read beats
        exp_b(4'd3, RESP_OKAY);
        do_write(4'd3, 24'h000100, 8'd15, BURST_INCR, 32'd0, 4'hF, 15);
        wait_drain(cyc);
        for (int i = 0; i < 16; i++) exp_r(4'd5, 32'(i), RESP_OKAY, i == 15);
        do_read(4'd5, 24'h000100, 8'd15, BURST_INCR);
        wait_drain(cyc);
        check("r_no_bubble_cycles", 32'(cyc), 32'd16);

        // backpressure on B and R
        exp_b(4'd4, RESP_OKAY);
        s_axi_bready = 1'b0;
        do_write(4'd4, 24'h000200, 8'd3, BURST_INCR, 32'hA0, 4'hF, 3);
        for (int i = 0; i < 5; i++) begin
            check("bvalid_held", 32'(s_axi_bvalid), 1);
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b1;
        wait_drain(cyc);
        bp_mode = 1'b1;
        for (int i = 0; i < 4; i++) exp_r(4'd6, 32'hA0 + 32'(i), RESP_OKAY, i == 3);
        do_read(4'd6, 24'h000200, 8'd3, BURST_INCR);
        wait_drain(cyc);
        bp_mode = 1'b0;

        // byte strobes: bytes 0 and 2 replaced
        exp_b(4'd1, RESP_OKAY);
        do_write(4'd1, 24'h000300, 8'd0, BURST_INCR, 32'h11223344, 4'hF, 0);
        exp_b(4'd1, RESP_OKAY);
        do_write(4'd1, 24'h000300, 8'd0, BURST_INCR, 32'hAABBCCDD, 4'h5, 0);
        wait_drain(cyc);
        exp_r(4'd1, 32'h11BB33DD, RESP_OKAY, 1'b1);
        do_read(4'd1, 24'h000300, 8'd0, BURST_INCR);
        wait_drain(cyc);

        // WRAP burst: SLVERR and memory untouched; WRAP read returns zeros
        exp_b(4'd2, RESP_OKAY);
        do_write(4'd2, 24'h000400, 8'd1, BURST_INCR, 32'hCAFE0000, 4'hF, 1);
        exp_b(4'd2, RESP_SLVERR);
        do_write(4'd2, 24'h000400, 8'd1, BURST_WRAP, 32'h12345678, 4'hF, 1);
        wait_drain(cyc);
        exp_r(4'd3, 32'hCAFE0000, RESP_OKAY, 1'b0);
        exp_r(4'd3, 32'hCAFE0001, RESP_OKAY, 1'b1);
        do_read(4'd3, 24'h000400, 8'd1, BURST_INCR);
        wait_drain(cyc);
        exp_r(4'd3, 32'h0, RESP_SLVERR, 1'b0);
        exp_r(4'd3, 32'h0, RESP_SLVERR, 1'b1);
        do_read(4'd3, 24'h000400, 8'd1, BURST_WRAP);
        wait_drain(cyc);

        // out-of-range word index, alone and straddling the top word
        exp_r(4'd4, 32'h0, RESP_SLVERR, 1'b1);
        do_read(4'd4, 24'(DEPTH * 4), 8'd0, BURST_INCR);
        wait_drain(cyc);
        exp_b(4'd4, RESP_SLVERR);
        do_write(4'd4, 24'(DEPTH * 4 - 4), 8'd1, BURST_INCR, 32'h77000000, 4'hF, 1);
        wait_drain(cyc);
        exp_r(4'd4, 32'h77000000, RESP_OKAY, 1'b0);
        exp_r(4'd4, 32'h0, RESP_SLVERR, 1'b1);
        do_read(4'd4, 24'(DEPTH * 4 - 4), 8'd1, BURST_INCR);
        wait_drain(cyc);

        // early wlast: all four beats still accepted and written
        exp_b(4'd5, RESP_SLVERR);
        do_write(4'd5, 24'h000500, 8'd3, BURST_INCR, 32'hB0, 4'hF, 2);
        wait_drain(cyc);
        for (int i = 0; i < 4; i++) exp_r(4'd5, 32'hB0 + 32'(i), RESP_OKAY, i == 3);
        do_read(4'd5, 24'h000500, 8'd3, BURST_INCR);
        wait_drain(cyc);

        // FIXED bursts hold the address
        exp_b(4'd6, RESP_OKAY);
        do_write(4'd6, 24'h000600, 8'd2, BURST_FIXED, 32'hC0, 4'hF, 2);
        wait_drain(cyc);
        exp_r(4'd6, 32'hC2, RESP_OKAY, 1'b0);
        exp_r(4'd6, 32'hC2, RESP_OKAY, 1'b1);
        do_read(4'd6, 24'h000600, 8'd1, BURST_FIXED);
        wait_drain(cyc);

        // reset while beat 3 of a 16-beat read is presented
        for (int i = 0; i < 16; i++) exp_r(4'd7, 32'(i), RESP_OKAY, i == 15);
        do_read(4'd7, 24'h000100, 8'd15, BURST_INCR);
        n = 0;
        while (rq.size() > 13 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timeout("beat3_wait");
        check("pre_reset_rdata", s_axi_rdata, 32'd3);
        rst_n = 1'b0;
        #1;
        rq.delete();
        check("mid_rst_rvalid",  32'(s_axi_rvalid),  0);
        check("mid_rst_arready", 32'(s_axi_arready), 0);
        check("mid_rst_awready", 32'(s_axi_awready), 0);
        check("mid_rst_wready",  32'(s_axi_wready),  0);
        check("mid_rst_bvalid",  32'(s_axi_bvalid),  0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_awready", 32'(s_axi_awready), 1);
        check("post_rst_arready", 32'(s_axi_arready), 1);
        exp_r(4'd8, 32'h55555555, RESP_OKAY, 1'b1);
        do_read(4'd8, 24'h000004, 8'd0, BURST_INCR);
        wait_drain(cyc);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
